// File: rtl/fpsub_if.sv
// Request/result bundle for the binary32 subtractor: operands and start in,
// registered difference plus done/busy status out.
interface fpsub_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        done;
    logic        busy;

    modport master (output start, a, b, input  diff, done, busy);
    modport slave  (input  start, a, b, output diff, done, busy);
endinterface

// File: rtl/fpsub.sv
// Multi-cycle binary32 subtractor (a - b): flush-to-zero, truncating,
// one-bit-per-cycle alignment and normalisation shifters.
module fpsub (
    input  logic   clk,
    input  logic   reset,
    fpsub_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic [31:0] sat_inf(input logic s);
        return {s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [31:0] sat_zero(input logic s);
        return {s, 31'd0};
    endfunction

    // Truncating pack: guard bits below the hidden one simply fall away.
    function automatic logic [31:0] pack(input logic s, input logic [7:0] e,
                                         input logic [22:0] f);
        return {s, e, f};
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] diff_q, diff_d;
    logic        done_q, done_d;
    logic        sx_q, sx_d;
    logic        sy_q, sy_d;
    logic [24:0] mx_q, mx_d;
    logic [24:0] my_q, my_d;
    logic [7:0]  exp_q, exp_d;
    logic [8:0]  cnt_q, cnt_d;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [8:0] exp_diff;
    logic        a_ge;
    logic [8:0]  cnt_mag;

    assign a_nan  = is_nan(a_q);
    assign b_nan  = is_nan(b_q);
    assign a_inf  = is_inf(a_q);
    assign b_inf  = is_inf(b_q);
    assign a_zero = is_zero(a_q);
    assign b_zero = is_zero(b_q);

    assign exp_diff = $signed({1'b0, a_q[30:23]}) - $signed({1'b0, b_q[30:23]});
    assign a_ge     = (exp_diff >= 9'sd0);
    assign cnt_mag  = a_ge ? exp_diff : -exp_diff;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        done_d  = done_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        mx_d    = mx_q;
        my_d    = my_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Subtraction is addition of b with its sign flipped.
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = {~bus.b[31], bus.b[30:0]};
                    done_d  = 1'b0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]))) begin
                    diff_d  = QNAN;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (a_inf) begin
                    diff_d  = a_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (b_inf) begin
                    diff_d  = b_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (a_zero && b_zero) begin
                    diff_d  = sat_zero(a_q[31] & b_q[31]);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (a_zero) begin
                    diff_d  = b_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (b_zero) begin
                    diff_d  = a_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // x carries the larger exponent, y is the one to align.
                    if (a_ge) begin
                        sx_d  = a_q[31];
                        mx_d  = {2'b01, a_q[22:0]};
                        sy_d  = b_q[31];
                        my_d  = {2'b01, b_q[22:0]};
                        exp_d = a_q[30:23];
                    end else begin
                        sx_d  = b_q[31];
                        mx_d  = {2'b01, b_q[22:0]};
                        sy_d  = a_q[31];
                        my_d  = {2'b01, a_q[22:0]};
                        exp_d = b_q[30:23];
                    end
                    cnt_d   = cnt_mag;
                    state_d = S_ALIGN;
                end
            end

            S_ALIGN: begin
                if (cnt_q > 9'd25) begin
                    my_d    = 25'd0;
                    cnt_d   = 9'd0;
                    state_d = S_ADD;
                end else if (cnt_q == 9'd0) begin
                    state_d = S_ADD;
                end else begin
                    my_d  = my_q >> 1;
                    cnt_d = cnt_q - 9'd1;
                end
            end

            S_ADD: begin
                if (sx_q == sy_q) begin
                    mx_d    = mx_q + my_q;
                    state_d = S_NORM;
                end else if (mx_q == my_q) begin
                    diff_d  = sat_zero(1'b0);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (mx_q > my_q) begin
                    mx_d    = mx_q - my_q;
                    state_d = S_NORM;
                end else begin
                    mx_d    = my_q - mx_q;
                    sx_d    = sy_q;
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                if (mx_q[24]) begin
                    if (exp_q == 8'hFE) begin
                        diff_d  = sat_inf(sx_q);
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mx_d  = mx_q >> 1;
                        exp_d = exp_q + 8'd1;
                    end
                end else if (!mx_q[23]) begin
                    if (exp_q == 8'h01) begin
                        diff_d  = sat_zero(sx_q);
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mx_d  = mx_q << 1;
                        exp_d = exp_q - 8'd1;
                    end
                end else begin
                    diff_d  = pack(sx_q, exp_q, mx_q[22:0]);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            diff_q  <= 32'd0;
            done_q  <= 1'b0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            mx_q    <= 25'd0;
            my_q    <= 25'd0;
            exp_q   <= 8'd0;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            done_q  <= done_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.diff = diff_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_fpsub.sv
// Directed bench for fpsub: hand-computed binary32 differences, special
// operands, latency bounds, ignored start while busy, and async reset.
module tb_fpsub;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    fpsub_if bus ();

    fpsub u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulse start for one edge and leave the bench at the negedge after it.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait for done; n returns the number of rising edges from the start edge.
    task automatic wait_done(output int n, output logic busy_ok);
        n       = 1;
        busy_ok = 1'b1;
        while (!bus.done && n < 70) begin
            busy_ok = busy_ok & bus.busy;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int max_lat);
        int   n;
        logic busy_ok;
        pulse_start(a, b);
        check({tag, "_done_cleared"}, {31'd0, bus.done}, 32'd0);
        wait_done(n, busy_ok);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_diff"}, bus.diff, exp);
        check({tag, "_busy_between"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_latency_ok"}, {31'd0, (n <= max_lat)}, 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int   n;
        logic busy_ok;
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        repeat (3) @(negedge clk);
        check("reset_diff", bus.diff, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start_busy", {31'd0, bus.busy}, 32'd0);

        run_op("3m1",        32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 53);
        run_op("1m1",        32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 53);
        run_op("1mneg1",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 53);
        run_op("1m3",        32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 53);
        run_op("big_m1",     32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 53);
        run_op("far_shift",  32'h4C80_0000, 32'h3F80_0000, 32'h4C80_0000, 53);
        run_op("overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 53);
        run_op("underflow",  32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 53);
        run_op("inf_m_inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2);
        run_op("nan_b",      32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 2);
        run_op("zero_m1",    32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 2);
        run_op("sub_m1",     32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000, 2);
        run_op("1_m_neginf", 32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, 2);
        run_op("nz_m_pz",    32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 2);
        run_op("nz_m_nz",    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2);

        // A second start while aligning must not disturb the first operation.
        pulse_start(32'h4B00_0000, 32'h3F80_0000);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h3F80_0000;
        bus.b     = 32'h3F80_0000;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_start_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(n, busy_ok);
        check("ignored_start_done", {31'd0, bus.done}, 32'd1);
        check("ignored_start_diff", bus.diff, 32'h4AFF_FFFE);

        // Reset mid-ALIGN clears outputs without waiting for a clock edge.
        pulse_start(32'h4B00_0000, 32'h3F80_0000);
        repeat (4) @(negedge clk);
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_diff", bus.diff, 32'd0);
        check("async_reset_done", {31'd0, bus.done}, 32'd0);
        check("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle_done", {31'd0, bus.done}, 32'd0);
        check("post_reset_idle_busy", {31'd0, bus.busy}, 32'd0);
        run_op("post_reset_3m1", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 53);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpsub.md
FPSUB -- requirements
Module: fpsub

Interface
REQ-001 Parameters: none; binary32 format fixed, subnormal inputs flushed to zero, rounding toward zero (truncation).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; samples a, b on the same edge.
REQ-005 a  input  32  IEEE 754 binary32 minuend.
REQ-006 b  input  32  IEEE 754 binary32 subtrahend.
REQ-007 diff  output  32  registered result a - b, valid while done=1.
REQ-008 done  output  1  result-valid flag, held until next accepted start or reset.
REQ-009 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-010 FSM states: IDLE, CHECK, ALIGN, ADD, NORM, DONE; one state per cycle, ALIGN and NORM may repeat.
REQ-011 start accepted only in IDLE or DONE: latch a and b, flip b sign bit (effective b' = -b), clear done, go to CHECK; start while busy ignored, inputs not re-sampled.
REQ-012 CHECK, operand class: exp==0xFF with mantissa!=0 is NaN; exp==0xFF with mantissa==0 is Inf; exp==0x00 is zero (subnormal mantissa discarded).
REQ-013 CHECK priority: any NaN -> diff=0x7FC00000; a Inf and b' Inf of opposite signs -> 0x7FC00000; a Inf -> a; b' Inf -> b'; a zero and b' zero -> signed zero (-0 only when both signs negative, else +0); a zero -> b'; b' zero -> a; special results go directly to DONE.
REQ-014 CHECK otherwise: form 24-bit mantissas {1, frac}, result exponent = larger exponent, shift count = exponent difference; go to ALIGN.
REQ-015 ALIGN: shift smaller-exponent mantissa right 1 bit per cycle, decrementing count; shifted-out bits discarded; count==0 -> ADD; count>25 -> smaller mantissa forced to 0 in one cycle, then ADD.
REQ-016 ADD (one cycle, 25-bit unsigned): equal signs -> magnitude sum, sign = common sign; different signs -> larger magnitude minus smaller, sign = sign of larger; equal magnitudes -> +0, go to DONE.
REQ-017 NORM: bit24 set -> shift right 1, exponent +1 (one cycle); bit23 clear -> shift left 1, exponent -1 per cycle; bit23 set and bit24 clear -> pack {sign, exp, mant[22:0]}, go to DONE.
REQ-018 Overflow: exponent reaching 0xFF -> diff = signed Inf (exp 0xFF, frac 0), go to DONE.
REQ-019 Underflow: exponent reaching 0 during left shift -> diff = signed zero, go to DONE.
REQ-020 Latency start-to-done: at most 1 + 26 + 1 + 24 + 1 = 53 cycles; specials 2 cycles.
REQ-021 DONE: done=1, diff stable; new start restarts at CHECK with done low the next cycle.

Reset
REQ-022 reset low at any time, including mid-ALIGN/NORM: immediately state=IDLE, diff=0x00000000, done=0, busy=0, internal registers cleared.
REQ-023 After reset release, no operation starts until start is sampled high.

Verification
REQ-024 a=0x40400000 (3.0), b=0x3F800000 (1.0) -> diff=0x40000000, done within 53 cycles, busy high in between.
REQ-025 a=0x3F800000, b=0x3F800000 -> diff=0x00000000; a=0x3F800000, b=0xBF800000 -> diff=0x40000000.
REQ-026 a=0x7F800000, b=0x7F800000 -> 0x7FC00000; a=0x3F800000, b=0x7FC00001 -> 0x7FC00000; a=0x00000000, b=0x3F800000 -> 0xBF800000, all in 2 cycles.
REQ-027 a=0x7F7FFFFF, b=0xFF7FFFFF -> diff=0x7F800000 (overflow to +Inf).
REQ-028 start pulsed while busy with different a/b -> ignored, original result delivered; reset low mid-ALIGN -> done=0, diff=0 asynchronously, next start computes correctly.
